i2c_master: RTL and testbench
=============================

I2C_MASTER -- requirements
Module: i2c_master

Interface
REQ-001 SHALL have parameter CLK_DIV, default 4: clk cycles per SCL quarter-period, legal range 2..255.
REQ-002 SHALL have port clk, input, 1: single system clock, all logic on rising edge.
REQ-003 SHALL have port reset_n, input, 1: asynchronous, active-low reset.
REQ-004 SHALL have port start, input, 1: starts one transaction; sampled only in IDLE.
REQ-005 SHALL have port rw, input, 1: 0 = write, 1 = read; captured with start.
REQ-006 SHALL have port slave_addr, input, 7: target address (e.g. 7'h40); captured with start.
REQ-007 SHALL have port wr_data, input, 8: write byte; captured with start.
REQ-008 SHALL have port rd_data, output, 8: byte received in a read transaction.
REQ-009 SHALL have port busy, output, 1: high from the cycle after start is accepted until the cycle done is asserted.
REQ-010 SHALL have port done, output, 1: one-cycle pulse at transaction end.
REQ-011 SHALL have port ack_err, output, 1: slave NACKed the address or write byte; valid with done.
REQ-012 SHALL have port sda, inout, 1: open-drain; drive 0 or z only.
REQ-013 SHALL have port scl, inout, 1: open-drain; drive 0 or z only.

Function
REQ-014 SHALL implement states IDLE, START, ADDR, ADDR_ACK, WDATA, WACK, RDATA, MACK, STOP.
REQ-015 SHALL define a bit as 4 quarter-phases of CLK_DIV cycles each: q0-q1 SCL low, q2-q3 SCL released.
REQ-016 SHALL change SDA only at q0 entry; sample SDA at the last cycle of q2.
REQ-017 START: SDA released, SCL released for 2 quarters; SDA pulled low for 2 quarters with SCL released; then go to ADDR.
REQ-018 ADDR: shift {slave_addr, rw} MSB first, 8 bits; then ADDR_ACK releases SDA for 1 bit.
REQ-019 ADDR_ACK with sampled 1 (NACK): set ack_err, go to STOP; sampled 0: go to WDATA if rw=0, else RDATA.
REQ-020 WDATA: shift wr_data MSB first; WACK releases SDA 1 bit; NACK sets ack_err; always go to STOP.
REQ-021 RDATA: SDA released, 8 bits sampled MSB first into a shift register; MACK drives SDA high (NACK, single byte); rd_data updated at MACK end.
REQ-022 STOP: SDA low with SCL low for 2 quarters, SCL released 1 quarter, SDA released 1 quarter; then done=1 for 1 cycle, return to IDLE.
REQ-023 Transaction length SHALL be exactly 20*4*CLK_DIV cycles from start accepted to done (no stretching).
REQ-024 start while busy SHALL be ignored; start in the same cycle done is asserted SHALL be ignored.
REQ-025 ack_err SHALL clear when a new start is accepted; rd_data SHALL hold its value until the next read completes.
REQ-026 A write transaction SHALL leave rd_data unchanged.

Reset
REQ-027 reset_n low SHALL asynchronously force IDLE, release sda and scl (z), and clear busy, done, ack_err, rd_data=8'h00 and all counters.
REQ-028 reset_n asserted mid-transaction SHALL abort without generating STOP; the first start after release SHALL be accepted normally.

Configuration
REQ-029 Macro I2C_MASTER_CLK_STRETCH_EN defined: in q2, the quarter counter SHALL hold while scl reads 0 (slave stretching) and resume when scl reads 1.
REQ-030 Macro I2C_MASTER_CLK_STRETCH_EN undefined: scl readback SHALL be ignored, and timing SHALL follow REQ-023 exactly.

Verification
REQ-031 Write, CLK_DIV=4, addr 7'h40, data 8'hA5, slave ACKs both -> bus bytes 8'h80, 8'hA5; done at cycle 320; ack_err=0.
REQ-032 Read, addr 7'h40, slave returns 8'h3C -> bus byte 8'h81, master NACK in MACK, rd_data=8'h3C, ack_err=0.
REQ-033 Write to addr 7'h41 with no slave (SDA pulled up) -> ack_err=1, no data byte on the bus, STOP generated, done 1 cycle.
REQ-034 reset_n pulsed low during bit 3 of WDATA -> sda and scl z within 0 cycles of assertion, busy=0, next write completes correctly.
REQ-035 start held high continuously -> back-to-back transactions, each with busy deasserted for at least 1 cycle between them; no start accepted while busy.
REQ-036 With I2C_MASTER_CLK_STRETCH_EN, slave holds SCL low 50 cycles in ADDR_ACK -> transaction lengthens by 50 cycles, data intact; without the macro, length stays at 320.

Source files
------------

// File: rtl/i2c_master.sv
// i2c_master: single-byte I2C master (one write or one read per start) on open-drain SDA/SCL.
// Define I2C_MASTER_CLK_STRETCH_EN to let a slave stretch SCL during the high phase.
module i2c_master #(
   parameter int unsigned CLK_DIV = 4
) (
   input  logic       clk,
   input  logic       reset_n,
   input  logic       start,
   input  logic       rw,
   input  logic [6:0] slave_addr,
   input  logic [7:0] wr_data,
   output logic [7:0] rd_data,
   output logic       busy,
   output logic       done,
   output logic       ack_err,
   inout  wire        sda,
   inout  wire        scl
);
   typedef enum logic [3:0] {IDLE, START, ADDR, ADDR_ACK, WDATA, WACK, RDATA, MACK, STOP} state_t;

   state_t     state_q, state_d;
   logic [7:0] cnt_q, cnt_d, sh_q, sh_d, wd_q, wd_d, rd_q, rd_d;
   logic [1:0] qtr_q, qtr_d;
   logic [2:0] bit_q, bit_d;
   logic       rw_q, rw_d, samp_q, samp_d, busy_q, busy_d, done_q, done_d, err_q, err_d;
   logic       scl_oe_q, scl_oe_d, sda_oe_q, sda_oe_d;
   logic       stall, tick, samp_now, bit_end;

`ifdef I2C_MASTER_CLK_STRETCH_EN
   assign stall = (state_q != IDLE) && (qtr_q == 2'd2) && !scl;
`else
   assign stall = 1'b0;
`endif

   assign tick     = (cnt_q == 8'(CLK_DIV - 1)) && !stall;
   assign samp_now = tick && (qtr_q == 2'd2);
   assign bit_end  = tick && (qtr_q == 2'd3);

   assign sda     = sda_oe_q ? 1'b0 : 1'bz;
   assign scl     = scl_oe_q ? 1'b0 : 1'bz;
   assign rd_data = rd_q;
   assign busy    = busy_q;
   assign done    = done_q;
   assign ack_err = err_q;

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      qtr_d   = qtr_q;
      bit_d   = bit_q;
      sh_d    = sh_q;
      wd_d    = wd_q;
      rw_d    = rw_q;
      samp_d  = samp_q;
      rd_d    = rd_q;
      busy_d  = busy_q;
      done_d  = 1'b0;
      err_d   = err_q;
      if (state_q != IDLE && !stall) begin
         cnt_d = tick ? 8'd0 : cnt_q + 8'd1;
         if (tick) qtr_d = qtr_q + 2'd1;
      end
      if (samp_now) samp_d = sda;
      case (state_q)
         IDLE: if (start && !done_q) begin
            state_d = START;
            busy_d  = 1'b1;
            err_d   = 1'b0;
            sh_d    = {slave_addr, rw};
            wd_d    = wr_data;
            rw_d    = rw;
            cnt_d   = 8'd0;
            qtr_d   = 2'd0;
            bit_d   = 3'd0;
         end
         START: if (bit_end) state_d = ADDR;
         ADDR, WDATA: if (bit_end) begin
            bit_d = bit_q + 3'd1;
            sh_d  = {sh_q[6:0], 1'b0};
            if (bit_q == 3'd7) state_d = (state_q == ADDR) ? ADDR_ACK : WACK;
         end
         ADDR_ACK: if (bit_end) begin
            err_d   = samp_q;
            state_d = samp_q ? STOP : rw_q ? RDATA : WDATA;
            sh_d    = wd_q;
         end
         WACK: if (bit_end) begin
            err_d   = samp_q;
            state_d = STOP;
         end
         RDATA: begin
            if (samp_now) sh_d = {sh_q[6:0], sda};
            if (bit_end) begin
               bit_d = bit_q + 3'd1;
               if (bit_q == 3'd7) state_d = MACK;
            end
         end
         MACK: if (bit_end) begin
            rd_d    = sh_q;
            state_d = STOP;
         end
         STOP: if (bit_end) begin
            state_d = IDLE;
            done_d  = 1'b1;
            busy_d  = 1'b0;
         end
         default: state_d = IDLE;
      endcase
      // Pin drive follows the next state so SDA/SCL change exactly on quarter entry
      scl_oe_d = !(state_d inside {IDLE, START}) && !qtr_d[1];
      sda_oe_d = (state_d == START) ? qtr_d[1] :
                 (state_d inside {ADDR, WDATA}) ? !sh_d[7] :
                 (state_d == STOP) ? (qtr_d != 2'd3) : 1'b0;
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q  <= IDLE;
         cnt_q    <= 8'd0;
         qtr_q    <= 2'd0;
         bit_q    <= 3'd0;
         sh_q     <= 8'd0;
         wd_q     <= 8'd0;
         rw_q     <= 1'b0;
         samp_q   <= 1'b0;
         rd_q     <= 8'd0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
         err_q    <= 1'b0;
         scl_oe_q <= 1'b0;
         sda_oe_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         qtr_q    <= qtr_d;
         bit_q    <= bit_d;
         sh_q     <= sh_d;
         wd_q     <= wd_d;
         rw_q     <= rw_d;
         samp_q   <= samp_d;
         rd_q     <= rd_d;
         busy_q   <= busy_d;
         done_q   <= done_d;
         err_q    <= err_d;
         scl_oe_q <= scl_oe_d;
         sda_oe_q <= sda_oe_d;
      end
   end
endmodule

// File: tb/tb_i2c_master.sv
// tb_i2c_master: bus-level slave model plus scoreboard of expected transaction results.
module tb_i2c_master;
   localparam int D = 4;
   localparam logic [6:0] SLV = 7'h40;

   logic       clk = 1'b0, reset_n = 1'b0, start = 1'b0, rw = 1'b0;
   logic [6:0] slave_addr = 7'h00;
   logic [7:0] wr_data = 8'h00;
   logic [7:0] rd_data;
   logic       busy, done, ack_err;
   wire        sda, scl;
   logic       s_sda_low = 1'b0;

   pullup (sda);
   pullup (scl);
   assign sda = s_sda_low ? 1'b0 : 1'bz;

   i2c_master #(.CLK_DIV(D)) dut (
      .clk(clk), .reset_n(reset_n), .start(start), .rw(rw), .slave_addr(slave_addr),
      .wr_data(wr_data), .rd_data(rd_data), .busy(busy), .done(done), .ack_err(ack_err),
      .sda(sda), .scl(scl)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int errors = 0, checks = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   typedef struct {
      logic       err;
      logic [7:0] rd;
      int         len;
      logic [7:0] abyte;
      int         ndata;
      logic [7:0] data;
      logic       chk_mack;
   } exp_t;
   exp_t sb_q[$];

   // Slave: samples the bus on clk negedges and acts on SCL/SDA changes it sees there
   logic       ps = 1'b1, pd = 1'b1, acked = 1'b0, s_stop = 1'b0, s_mack = 1'b0, nack_d = 1'b0;
   logic [7:0] sh = 8'h00, s_abyte = 8'h00, s_data = 8'h00, slv_rd = 8'h00;
   int         bitn = 0, s_nd = 0;

   always @(negedge clk) begin
      int b;
      if (ps && scl && pd && !sda) begin
         bitn = 0; s_stop = 1'b0; s_nd = 0; acked = 1'b0;
      end else if (ps && scl && !pd && sda) s_stop = 1'b1;
      if (!ps && scl) begin
         bitn++;
         if (bitn <= 8 || (bitn >= 10 && bitn <= 17)) sh = {sh[6:0], sda};
         if (bitn == 8) begin
            s_abyte = sh;
            acked = (sh[7:1] == SLV);
         end
         if (bitn == 17) begin
            s_nd++;
            s_data = sh;
         end
         if (bitn == 18) s_mack = sda;
      end
      if (ps && !scl) begin
         b = bitn + 1;
         s_sda_low = (b == 9 && acked) ||
                     (b >= 10 && b <= 17 && acked && s_abyte[0] && !slv_rd[17 - b]) ||
                     (b == 18 && acked && !s_abyte[0] && !nack_d);
      end
      ps = scl;
      pd = sda;
   end

   // Monitor: pops one expectation per done pulse
   logic pb = 1'b0;
   int   t0 = 0;
   exp_t m;
   always @(negedge clk) begin
      if (busy && !pb) t0 = cyc;
      if (done) begin
         chk("busy_at_done", busy, 0);
         if (sb_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL sb_empty: done with no expected transaction (t=%0t)", $time);
         end else begin
            m = sb_q.pop_front();
            chk("ack_err", ack_err, m.err);
            chk("rd_data", rd_data, m.rd);
            chk("length", cyc - t0, m.len);
            chk("addr_byte", s_abyte, m.abyte);
            chk("data_bytes", s_nd, m.ndata);
            if (m.ndata > 0) chk("data_byte", s_data, m.data);
            chk("stop_seen", s_stop, 1);
            if (m.chk_mack) chk("master_nack", s_mack, 1);
         end
      end
      pb = busy;
   end

   logic [7:0] mdl_rd = 8'h00;

   function automatic exp_t model(input logic r, input logic [6:0] a, input logic [7:0] w,
                                  input logic [7:0] sb, input logic nd);
      exp_t e;
      logic ack = (a == SLV);
      e.err      = !ack || (!r && nd);
      e.len      = (ack ? 20 : 11) * 4 * D;
      if (r && ack) mdl_rd = sb;
      e.rd       = mdl_rd;
      e.abyte    = {a, r};
      e.ndata    = ack ? 1 : 0;
      e.data     = r ? sb : w;
      e.chk_mack = r && ack;
      return e;
   endfunction

   task automatic wait_idle();
      int n = 0;
      while ((busy || done) && n < 2000) begin
         @(negedge clk);
         n++;
      end
      chk("idle_timeout", n < 2000, 1);
   endtask

   task automatic issue(input logic r, input logic [6:0] a, input logic [7:0] w,
                        input logic [7:0] sb, input logic nd);
      wait_idle();
      slv_rd = sb; nack_d = nd; rw = r; slave_addr = a; wr_data = w;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic txn(input logic r, input logic [6:0] a, input logic [7:0] w,
                      input logic [7:0] sb, input logic nd);
      int n = 0;
      sb_q.push_back(model(r, a, w, sb, nd));
      issue(r, a, w, sb, nd);
      while (!done && n < 2000) begin
         @(negedge clk);
         n++;
      end
      chk("done_timeout", done, 1);
      @(negedge clk);
   endtask

   initial begin
      repeat (3) @(negedge clk);
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_ack_err", ack_err, 0);
      chk("rst_rd_data", rd_data, 8'h00);
      chk("rst_sda", sda, 1);
      chk("rst_scl", scl, 1);
      reset_n = 1'b1;
      repeat (2) @(negedge clk);

      txn(1'b0, 7'h40, 8'hA5, 8'h00, 1'b0);
      txn(1'b1, 7'h40, 8'h00, 8'h3C, 1'b0);
      txn(1'b0, 7'h41, 8'h77, 8'h00, 1'b0);
      txn(1'b1, 7'h41, 8'h00, 8'h99, 1'b0);
      txn(1'b0, 7'h40, 8'hC3, 8'h00, 1'b1);
      chk("rd_hold_after_write", rd_data, 8'h3C);

      // Abort during the fourth data bit of a write; no done is expected for it
      issue(1'b0, 7'h40, 8'hA5, 8'h00, 1'b0);
      repeat (210) @(negedge clk);
      reset_n = 1'b0;
      #1;
      chk("abort_sda", sda, 1);
      chk("abort_scl", scl, 1);
      chk("abort_busy", busy, 0);
      chk("abort_rd_data", rd_data, 8'h00);
      mdl_rd = 8'h00;
      @(negedge clk);
      reset_n = 1'b1;
      @(negedge clk);
      txn(1'b0, 7'h40, 8'h5A, 8'h00, 1'b0);

      // start held high across three back-to-back writes
      begin
         int n = 0;
         wait_idle();
         for (int k = 0; k < 3; k++) sb_q.push_back(model(1'b0, SLV, 8'h96, 8'h00, 1'b0));
         slv_rd = 8'h00; nack_d = 1'b0; rw = 1'b0; slave_addr = SLV; wr_data = 8'h96;
         start = 1'b1;
         for (int k = 0; k < 3; k++) begin
            while (!busy && n < 6000) begin
               @(negedge clk);
               n++;
            end
            if (k == 2) start = 1'b0;
            while (busy && n < 6000) begin
               @(negedge clk);
               n++;
            end
         end
         start = 1'b0;
         chk("held_timeout", n < 6000, 1);
         repeat (2) @(negedge clk);
      end

      for (int i = 0; i < 20; i++) begin
         logic       r  = 1'($urandom);
         logic [6:0] a  = ($urandom_range(3) == 0) ? 7'($urandom) : SLV;
         logic [7:0] w  = 8'($urandom);
         logic [7:0] sb = 8'($urandom);
         logic       nd = ($urandom_range(3) == 0);
         txn(r, a, w, sb, nd);
      end

      repeat (5) @(negedge clk);
      chk("sb_drained", sb_q.size(), 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
